// File: rtl/core_pkg.sv
// Shared core types: data word, register index and rd writeback source.
package core_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_idx_t;

  typedef enum logic [1:0] {
    RD_SRC_ALU,
    RD_SRC_MEM,
    RD_SRC_CSR,
    RD_SRC_PC_PLUS_4
  } rd_src_e;

  localparam word_t PC_STEP = 32'd4;
endpackage

// File: rtl/core_s2_result_commit_if.sv
// Stage-2 commit bundle: issue handshake, AMO dcache port, rd write port.
interface core_s2_result_commit_if;
  import core_pkg::*;

  logic     in_valid;
  logic     in_ready;
  logic     in_flush;
  logic     in_is_amo;
  logic     in_rd_we;
  reg_idx_t in_rd_idx;
  rd_src_e  in_rd_src;
  word_t    alu_result;
  word_t    dcache_data_out;
  word_t    csr_data_out;
  word_t    current_pc;
  logic     dcache_rd_req;
  logic     dcache_rsp_valid;
  logic     dcache_wr_req;
  word_t    dcache_wr_data;
  logic     dcache_wr_ack;
  logic     rd_wr_en;
  reg_idx_t rd_wr_idx;
  word_t    rd_wr_data;

  modport master (
    output in_valid, in_flush, in_is_amo,
    output in_rd_we, in_rd_idx, in_rd_src,
    output alu_result, dcache_data_out,
    output csr_data_out, current_pc,
    output dcache_rsp_valid, dcache_wr_ack,
    input  in_ready, dcache_rd_req,
    input  dcache_wr_req, dcache_wr_data,
    input  rd_wr_en, rd_wr_idx, rd_wr_data
  );

  modport slave (
    input  in_valid, in_flush, in_is_amo,
    input  in_rd_we, in_rd_idx, in_rd_src,
    input  alu_result, dcache_data_out,
    input  csr_data_out, current_pc,
    input  dcache_rsp_valid, dcache_wr_ack,
    output in_ready, dcache_rd_req,
    output dcache_wr_req, dcache_wr_data,
    output rd_wr_en, rd_wr_idx, rd_wr_data
  );
endinterface

// File: rtl/core_s2_rd_src_mux.sv
// Combinational rd writeback source select.
module core_s2_rd_src_mux
  import core_pkg::*;
(
  input  rd_src_e sel,
  input  word_t   alu_result,
  input  word_t   mem_data,
  input  word_t   csr_data,
  input  word_t   current_pc,
  output word_t   rd_data
);

  always_comb begin
    rd_data = '0;
    case (sel)
      RD_SRC_ALU:       rd_data = alu_result;
      RD_SRC_MEM:       rd_data = mem_data;
      RD_SRC_CSR:       rd_data = csr_data;
      RD_SRC_PC_PLUS_4: rd_data = current_pc + PC_STEP;
      default:          rd_data = '0;
    endcase
  end

endmodule

// File: rtl/core_s2_result_commit.sv
// Stage-2 result commit: rd writeback select plus AMO
// load / modify / store / writeback sequencing.
module core_s2_result_commit
  import core_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  core_s2_result_commit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AMO_LOAD,
    S_AMO_STORE
  } state_e;

  state_e   state_q, state_d;
  word_t    old_q, old_d;
  word_t    new_q, new_d;
  logic     amo_we_q, amo_we_d;
  reg_idx_t amo_idx_q, amo_idx_d;
  logic     wr_en_q, wr_en_d;
  reg_idx_t wr_idx_q, wr_idx_d;
  word_t    wr_data_q, wr_data_d;

  word_t mux_data;
  logic  accept;

  core_s2_rd_src_mux u_mux (
    .sel        (bus.in_rd_src),
    .alu_result (bus.alu_result),
    .mem_data   (bus.dcache_data_out),
    .csr_data   (bus.csr_data_out),
    .current_pc (bus.current_pc),
    .rd_data    (mux_data)
  );

  assign accept = bus.in_valid & ~bus.in_flush
                & (state_q == S_IDLE);

  always_comb begin
    state_d   = state_q;
    old_d     = old_q;
    new_d     = new_q;
    amo_we_d  = amo_we_q;
    amo_idx_d = amo_idx_q;
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept && bus.in_is_amo) begin
          amo_we_d  = bus.in_rd_we;
          amo_idx_d = bus.in_rd_idx;
          state_d   = S_AMO_LOAD;
        end else if (accept) begin
          wr_en_d   = bus.in_rd_we
                    & (bus.in_rd_idx != '0);
          wr_idx_d  = bus.in_rd_idx;
          wr_data_d = mux_data;
        end
      end
      // Flush wins over a same-cycle load response.
      S_AMO_LOAD: begin
        if (bus.in_flush) begin
          state_d = S_IDLE;
        end else if (bus.dcache_rsp_valid) begin
          old_d   = bus.dcache_data_out;
          new_d   = bus.alu_result;
          state_d = S_AMO_STORE;
        end
      end
      S_AMO_STORE: begin
        if (bus.dcache_wr_ack) begin
          state_d   = S_IDLE;
          wr_en_d   = amo_we_q & (amo_idx_q != '0);
          wr_idx_d  = amo_idx_q;
          wr_data_d = old_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      old_q     <= '0;
      new_q     <= '0;
      amo_we_q  <= 1'b0;
      amo_idx_q <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      old_q     <= old_d;
      new_q     <= new_d;
      amo_we_q  <= amo_we_d;
      amo_idx_q <= amo_idx_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.in_ready       = (state_q == S_IDLE);
  assign bus.dcache_rd_req  = (state_q == S_AMO_LOAD);
  assign bus.dcache_wr_req  = (state_q == S_AMO_STORE);
  assign bus.dcache_wr_data = (state_q == S_AMO_STORE)
                            ? new_q : '0;
  assign bus.rd_wr_en       = wr_en_q;
  assign bus.rd_wr_idx      = wr_idx_q;
  assign bus.rd_wr_data     = wr_data_q;

endmodule

// File: tb/tb_core_s2_result_commit.sv
// Bench for core_s2_result_commit: expected rd writes go
// through a scoreboard queue; FSM outputs checked per task.
module tb_core_s2_result_commit;
  import core_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [36:0] exp_q[$];

  core_s2_result_commit_if bus();

  core_s2_result_commit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid         = 1'b0;
    bus.in_flush         = 1'b0;
    bus.in_is_amo        = 1'b0;
    bus.in_rd_we         = 1'b0;
    bus.in_rd_idx        = '0;
    bus.in_rd_src        = RD_SRC_ALU;
    bus.alu_result       = '0;
    bus.dcache_data_out  = '0;
    bus.csr_data_out     = '0;
    bus.current_pc       = '0;
    bus.dcache_rsp_valid = 1'b0;
    bus.dcache_wr_ack    = 1'b0;
  endtask

  // Scoreboard: every rd write must match the queue head.
  always @(negedge clk) begin
    if (!rst && bus.rd_wr_en === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rd_write idx=%0d data=%h",
                 bus.rd_wr_idx, bus.rd_wr_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({bus.rd_wr_idx, bus.rd_wr_data} !== e) begin
          n_fail++;
          $display("FAIL rd_write got idx=%0d data=%h exp idx=%0d data=%h",
                   bus.rd_wr_idx, bus.rd_wr_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic check_drained(string name);
    step();
    step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain pending=%0d exp=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic amo, input logic we,
                       input reg_idx_t idx, input rd_src_e src);
    bus.in_valid  = 1'b1;
    bus.in_is_amo = amo;
    bus.in_rd_we  = we;
    bus.in_rd_idx = idx;
    bus.in_rd_src = src;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.rd_wr_en !== 1'b0 ||
        bus.dcache_rd_req !== 1'b0 || bus.dcache_wr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl rdy=%b we=%b rreq=%b wreq=%b exp 1000",
               bus.in_ready, bus.rd_wr_en,
               bus.dcache_rd_req, bus.dcache_wr_req);
    end
    n_tests++;
    if (bus.rd_wr_idx !== 5'd0 || bus.rd_wr_data !== 32'd0 ||
        bus.dcache_wr_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data idx=%0d data=%h wdata=%h exp 0",
               bus.rd_wr_idx, bus.rd_wr_data, bus.dcache_wr_data);
    end
    step();
  endtask

  task automatic test_alu_sources();
    issue(1'b0, 1'b1, 5'd5, RD_SRC_ALU);
    bus.alu_result = 32'h0000_1234;
    exp_q.push_back({5'd5, 32'h0000_1234});
    step();
    issue(1'b0, 1'b1, 5'd12, RD_SRC_MEM);
    bus.dcache_data_out = 32'hDEAD_BEEF;
    exp_q.push_back({5'd12, 32'hDEAD_BEEF});
    step();
    issue(1'b0, 1'b1, 5'd31, RD_SRC_CSR);
    bus.csr_data_out = 32'h8000_0001;
    exp_q.push_back({5'd31, 32'h8000_0001});
    step();
    issue(1'b0, 1'b0, 5'd9, RD_SRC_ALU);
    step();
    idle_inputs();
    check_drained("alu_sources");
  endtask

  task automatic test_jal();
    issue(1'b0, 1'b1, 5'd1, RD_SRC_PC_PLUS_4);
    bus.current_pc = 32'hFFFF_FFFC;
    exp_q.push_back({5'd1, 32'h0000_0000});
    step();
    bus.current_pc = 32'h0000_1000;
    bus.in_rd_idx  = 5'd2;
    exp_q.push_back({5'd2, 32'h0000_1004});
    step();
    for (int s = 0; s < 4; s++) begin
      issue(1'b0, 1'b1, 5'd0, rd_src_e'(s));
      bus.alu_result = 32'h1111_1111;
      step();
    end
    idle_inputs();
    check_drained("jal_x0");
  endtask

  task automatic test_amo();
    issue(1'b1, 1'b1, 5'd7, RD_SRC_ALU);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.dcache_rd_req !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.dcache_wr_req !== 1'b0 || bus.rd_wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL amo_load rreq=%b rdy=%b wreq=%b we=%b exp 1000",
                 bus.dcache_rd_req, bus.in_ready,
                 bus.dcache_wr_req, bus.rd_wr_en);
      end
      step();
    end
    bus.dcache_rsp_valid = 1'b1;
    bus.dcache_data_out  = 32'h10;
    bus.alu_result       = 32'h15;
    step();
    idle_inputs();
    bus.dcache_data_out = 32'hAAAA_AAAA;
    bus.alu_result      = 32'hBBBB_BBBB;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.dcache_wr_req !== 1'b1 || bus.dcache_wr_data !== 32'h15 ||
          bus.in_ready !== 1'b0 || bus.dcache_rd_req !== 1'b0) begin
        n_fail++;
        $display("FAIL amo_store wreq=%b wdata=%h rdy=%b rreq=%b exp 1 15 0 0",
                 bus.dcache_wr_req, bus.dcache_wr_data,
                 bus.in_ready, bus.dcache_rd_req);
      end
      step();
    end
    bus.dcache_wr_ack = 1'b1;
    exp_q.push_back({5'd7, 32'h10});
    step();
    bus.dcache_wr_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.dcache_wr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL amo_done rdy=%b wreq=%b exp 1 0",
               bus.in_ready, bus.dcache_wr_req);
    end
    check_drained("amo");
  endtask

  task automatic test_flush_load();
    issue(1'b1, 1'b1, 5'd8, RD_SRC_ALU);
    step();
    idle_inputs();
    bus.in_flush         = 1'b1;
    bus.dcache_rsp_valid = 1'b1;
    bus.dcache_data_out  = 32'h55;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.in_ready !== 1'b1 || bus.dcache_wr_req !== 1'b0 ||
          bus.dcache_rd_req !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_load rdy=%b wreq=%b rreq=%b exp 1 0 0",
                 bus.in_ready, bus.dcache_wr_req, bus.dcache_rd_req);
      end
      step();
    end
    check_drained("flush_load");
  endtask

  task automatic test_flush_store_idle();
    issue(1'b1, 1'b1, 5'd20, RD_SRC_ALU);
    step();
    idle_inputs();
    bus.dcache_rsp_valid = 1'b1;
    bus.dcache_data_out  = 32'h0000_0077;
    bus.alu_result       = 32'h0000_0099;
    step();
    idle_inputs();
    bus.in_flush = 1'b1;
    step();
    @(negedge clk);
    n_tests++;
    if (bus.dcache_wr_req !== 1'b1 || bus.dcache_wr_data !== 32'h99) begin
      n_fail++;
      $display("FAIL flush_store wreq=%b wdata=%h exp 1 99",
               bus.dcache_wr_req, bus.dcache_wr_data);
    end
    bus.dcache_wr_ack = 1'b1;
    exp_q.push_back({5'd20, 32'h77});
    step();
    idle_inputs();
    check_drained("flush_store");
    issue(1'b1, 1'b1, 5'd3, RD_SRC_ALU);
    bus.in_flush = 1'b1;
    step();
    issue(1'b0, 1'b1, 5'd4, RD_SRC_ALU);
    bus.in_flush = 1'b1;
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.dcache_rd_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle rdy=%b rreq=%b exp 1 0",
               bus.in_ready, bus.dcache_rd_req);
    end
    check_drained("flush_idle");
  endtask

  task automatic test_flush_after_accept();
    issue(1'b0, 1'b1, 5'd11, RD_SRC_ALU);
    bus.alu_result = 32'hCAFE_0011;
    exp_q.push_back({5'd11, 32'hCAFE_0011});
    step();
    idle_inputs();
    bus.in_flush = 1'b1;
    step();
    idle_inputs();
    check_drained("flush_after");
  endtask

  task automatic test_reset_store();
    issue(1'b1, 1'b1, 5'd6, RD_SRC_ALU);
    step();
    idle_inputs();
    bus.dcache_rsp_valid = 1'b1;
    bus.dcache_data_out  = 32'h1;
    bus.alu_result       = 32'h2;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.dcache_wr_req !== 1'b0 ||
        bus.dcache_rd_req !== 1'b0 || bus.rd_wr_en !== 1'b0 ||
        bus.dcache_wr_data !== 32'd0 || bus.rd_wr_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_store rdy=%b wreq=%b rreq=%b we=%b wd=%h rd=%h exp 1 0 0 0 0 0",
               bus.in_ready, bus.dcache_wr_req, bus.dcache_rd_req,
               bus.rd_wr_en, bus.dcache_wr_data, bus.rd_wr_data);
    end
    bus.dcache_wr_ack = 1'b1;
    step();
    idle_inputs();
    check_drained("reset_store");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      word_t v;
      v = $urandom();
      issue(1'b0, 1'b1, reg_idx_t'(i + 13), RD_SRC_ALU);
      bus.alu_result = v;
      exp_q.push_back({reg_idx_t'(i + 13), v});
      @(negedge clk);
      n_tests++;
      if (bus.in_ready !== 1'b1 ||
          (i > 0 && bus.rd_wr_en !== 1'b1)) begin
        n_fail++;
        $display("FAIL b2b_%0d rdy=%b we=%b exp 1 1",
                 i, bus.in_ready, bus.rd_wr_en);
      end
      step();
    end
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (bus.rd_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_last we=%b exp 1", bus.rd_wr_en);
    end
    check_drained("b2b");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    idle_inputs();
    test_reset();
    test_alu_sources();
    test_jal();
    test_amo();
    test_flush_load();
    test_flush_store_idle();
    test_flush_after_accept();
    test_reset_store();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
